// File: rtl/ad1860_tx_if.sv
// Sample-pair handshake between the upstream I2S deserializer and ad1860_tx.
// Signals:
//   l_sample_i / r_sample_i : 24-bit two's-complement left/right samples
//   valid_i                 : sample pair present
//   ready_o                 : transmitter holding buffer empty
// A pair transfers on a cycle where valid_i and ready_o are both high.
interface ad1860_tx_if;
  localparam int unsigned SAMPLE_W = 24;

  logic [SAMPLE_W-1:0] l_sample_i;
  logic [SAMPLE_W-1:0] r_sample_i;
  logic                valid_i;
  logic                ready_o;

  modport master (output l_sample_i, output r_sample_i, output valid_i, input ready_o);
  modport slave  (input l_sample_i, input r_sample_i, input valid_i, output ready_o);
endinterface

// File: rtl/ad1860_tx.sv
// Parallel-to-serial transmitter for a pair of AD1860-style DACs.
// Each accepted 24-bit sample pair is optionally dithered, rounded half-up and
// saturated to WORD bits, parked in a one-entry holding buffer, then shifted
// MSB-first on sdo_l_o/sdo_r_o with a shared bit clock and closed by an le_o
// low pulse (DACs latch on its falling edge).
// Ports:
//   mck_i    : system clock, rising edge
//   rst_i    : synchronous reset, active-high
//   bus      : sample-pair handshake (slave side)
//   bck_o    : free-running DAC bit clock, 2*CLK_DIV mck cycles per period
//   sdo_l_o  : left serial data
//   sdo_r_o  : right serial data
//   le_o     : shared latch enable
//   busy_o   : word shift/latch sequence in progress
module ad1860_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned WORD    = 18,
  parameter int unsigned LE_LOW  = 2,
  parameter int unsigned DITHER  = 0
) (
  input  logic mck_i,
  input  logic rst_i,
  ad1860_tx_if.slave bus,
  output logic bck_o,
  output logic sdo_l_o,
  output logic sdo_r_o,
  output logic le_o,
  output logic busy_o
);

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned EXT_W    = SAMPLE_W + 1;
  localparam int unsigned CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BC_MAX   = (WORD > LE_LOW) ? WORD : LE_LOW;
  localparam int unsigned BC_W     = $clog2(BC_MAX + 1);
  localparam int unsigned LFSR_W   = 6;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0]   BC_WORD  = BC_W'(WORD);
  localparam logic [BC_W-1:0]   BC_LATCH = BC_W'(LE_LOW - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (WORD - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] RND     = EXT_W'(1 << (23 - WORD));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bck_q, bck_d;
  logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD-1:0]     sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [WORD-1:0]     buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic                buf_full_q, buf_full_d;
  logic                ready_q, ready_d;
  logic                sdo_l_q, sdo_l_d, sdo_r_q, sdo_r_d;
  logic                le_q, le_d;
  logic                busy_q, busy_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;

  logic wrap_c, fall_tick_c, accept_c;

  // Dither, round half-up and saturate one channel to WORD bits.
  function automatic logic [WORD-1:0] condition(input logic [SAMPLE_W-1:0] s,
                                                input logic [LFSR_W-1:0]   n);
    logic signed [EXT_W-1:0] d;
    logic signed [EXT_W-1:0] x;
    logic signed [EXT_W-1:0] y;
    d = (DITHER != 0) ? ($signed(EXT_W'(n)) - EXT_W'(32)) : '0;
    x = $signed({s[SAMPLE_W-1], s}) + d + RND;
    y = x >>> (SAMPLE_W - WORD);
    if (y > SAT_MAX)      condition = SAT_MAX[WORD-1:0];
    else if (y < SAT_MIN) condition = SAT_MIN[WORD-1:0];
    else                  condition = y[WORD-1:0];
  endfunction

  // State and output registers.
  always_ff @(posedge mck_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bck_q      <= 1'b0;
      bitcnt_q   <= '0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b1;
      sdo_l_q    <= 1'b0;
      sdo_r_q    <= 1'b0;
      le_q       <= 1'b1;
      busy_q     <= 1'b0;
      lfsr_q     <= LFSR_W'(1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bck_q      <= bck_d;
      bitcnt_q   <= bitcnt_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      buf_full_q <= buf_full_d;
      ready_q    <= ready_d;
      sdo_l_q    <= sdo_l_d;
      sdo_r_q    <= sdo_r_d;
      le_q       <= le_d;
      busy_q     <= busy_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Divider, holding buffer, LFSR and word sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bck_d      = bck_q;
    bitcnt_d   = bitcnt_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    buf_full_d = buf_full_q;
    sdo_l_d    = sdo_l_q;
    sdo_r_d    = sdo_r_q;
    le_d       = le_q;
    lfsr_d     = lfsr_q;

    wrap_c      = (cnt_q == CNT_LAST);
    fall_tick_c = bck_q & wrap_c;
    accept_c    = bus.valid_i & ready_q;

    cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    bck_d = wrap_c ? ~bck_q : bck_q;

    // Accept and load are exclusive: one needs the buffer empty, the other full.
    if (accept_c) begin
      buf_l_d    = condition(bus.l_sample_i, lfsr_q);
      buf_r_d    = condition(bus.r_sample_i, lfsr_q);
      buf_full_d = 1'b1;
      lfsr_d     = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[1]};
    end

    // Everything serial moves on the bck falling edge so it is settled at the rise.
    case (state_q)
      IDLE: begin
        if (fall_tick_c && buf_full_q) begin
          sdo_l_d    = buf_l_q[WORD-1];
          sdo_r_d    = buf_r_q[WORD-1];
          sh_l_d     = buf_l_q << 1;
          sh_r_d     = buf_r_q << 1;
          bitcnt_d   = BC_W'(1);
          buf_full_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_tick_c) begin
          if (bitcnt_q == BC_WORD) begin
            sdo_l_d  = 1'b0;
            sdo_r_d  = 1'b0;
            le_d     = 1'b0;
            bitcnt_d = '0;
            state_d  = LATCH;
          end else begin
            sdo_l_d  = sh_l_q[WORD-1];
            sdo_r_d  = sh_r_q[WORD-1];
            sh_l_d   = sh_l_q << 1;
            sh_r_d   = sh_r_q << 1;
            bitcnt_d = bitcnt_q + BC_W'(1);
          end
        end
      end
      LATCH: begin
        // bitcnt reused to count bck periods with le low.
        if (fall_tick_c) begin
          if (bitcnt_q == BC_LATCH) begin
            le_d     = 1'b1;
            bitcnt_d = '0;
            state_d  = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + BC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = ~buf_full_d;
    busy_d  = (state_d != IDLE);
  end

  assign bus.ready_o = ready_q;
  assign bck_o       = bck_q;
  assign sdo_l_o     = sdo_l_q;
  assign sdo_r_o     = sdo_r_q;
  assign le_o        = le_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ad1860_tx.sv
// Scoreboard bench for ad1860_tx: three instances with different divider,
// word, latch and dither settings run concurrently. Stimulus pushes expected
// words (spec constants or a behavioural model) into per-instance queues; a
// per-instance monitor deserializes the DAC stream and pops/compares.
module tb_ad1860_tx;

  localparam int NI = 3;

  typedef struct {
    int l;
    int r;
  } pair_t;

  function automatic int cd_of(input int i);
    case (i) 0: return 2; 1: return 1; default: return 3;
    endcase
  endfunction
  function automatic int wd_of(input int i);
    case (i) 0: return 18; 1: return 18; default: return 16;
    endcase
  endfunction
  function automatic int ll_of(input int i);
    case (i) 0: return 2; 1: return 2; default: return 1;
    endcase
  endfunction
  function automatic int di_of(input int i);
    case (i) 0: return 0; default: return 1;
    endcase
  endfunction

  logic        mck;
  logic        rst_v [NI];
  logic        vld   [NI];
  logic [23:0] ls    [NI];
  logic [23:0] rs    [NI];
  logic        rdy   [NI];
  logic        bck   [NI];
  logic        sdo_l [NI];
  logic        sdo_r [NI];
  logic        le    [NI];
  logic        busy  [NI];

  pair_t expq [NI][$];
  int    lfsr_m [NI];
  int    n_vec = 0;
  int    n_err = 0;

  initial begin
    mck = 1'b0;
    forever #5 mck = ~mck;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input int i, input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got 0x%0h, required 0x%0h", i, nm, act, exp);
    end
  endtask

  // Reference conditioning: plain integer arithmetic from the rules.
  function automatic int ref_word(input logic [23:0] s, input int n, input int wd, input int di);
    int x, y, hi, lo;
    x = int'($signed(s));
    if (di != 0) x = x + n - 32;
    y  = (x + (1 << (23 - wd))) >>> (24 - wd);
    hi = (1 << (wd - 1)) - 1;
    lo = -(1 << (wd - 1));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y & ((1 << wd) - 1);
  endfunction

  function automatic int lfsr_next(input int n);
    return ((n << 1) & 63) | (((n >> 5) ^ (n >> 4) ^ (n >> 1)) & 1);
  endfunction

  function automatic logic [23:0] rnd_sample();
    case ($urandom_range(0, 5))
      0:       return 24'h7FFFFF - 24'($urandom_range(0, 200));
      1:       return 24'h800000 + 24'($urandom_range(0, 200));
      default: return 24'($urandom);
    endcase
  endfunction

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : gi
      localparam int WD   = wd_of(g);
      localparam int LL   = ll_of(g);
      localparam int MASK = (1 << WD) - 1;

      ad1860_tx_if bus_i ();
      assign bus_i.l_sample_i = ls[g];
      assign bus_i.r_sample_i = rs[g];
      assign bus_i.valid_i    = vld[g];
      assign rdy[g]           = bus_i.ready_o;

      ad1860_tx #(
        .CLK_DIV(cd_of(g)),
        .WORD   (wd_of(g)),
        .LE_LOW (ll_of(g)),
        .DITHER (di_of(g))
      ) dut (
        .mck_i  (mck),
        .rst_i  (rst_v[g]),
        .bus    (bus_i),
        .bck_o  (bck[g]),
        .sdo_l_o(sdo_l[g]),
        .sdo_r_o(sdo_r[g]),
        .le_o   (le[g]),
        .busy_o (busy[g])
      );

      // Monitor: capture bits at bck rises, close words on le falls.
      initial begin : mon
        logic  pb, pl, pr, pe, pbz;
        int    acc_l, acc_r, nb, nlow;
        pair_t p;
        pb = 0; pl = 0; pr = 0; pe = 1; pbz = 0;
        acc_l = 0; acc_r = 0; nb = 0; nlow = 0;
        forever begin
          @(negedge mck);
          if (rst_v[g] !== 1'b0) begin
            pb = 0; pl = 0; pr = 0; pe = 1; pbz = 0;
            acc_l = 0; acc_r = 0; nb = 0; nlow = 0;
            continue;
          end
          if (sdo_l[g] != pl || sdo_r[g] != pr || le[g] != pe)
            check(g, "change_on_bck_fall", int'(pb && !bck[g]), 1);
          if (busy[g] && !pbz) begin
            acc_l = 0; acc_r = 0; nb = 0;
          end
          if (!pb && bck[g]) begin
            if (le[g]) begin
              acc_l = (acc_l << 1) | int'(sdo_l[g]);
              acc_r = (acc_r << 1) | int'(sdo_r[g]);
              nb++;
            end else begin
              nlow++;
            end
          end
          if (pe && !le[g]) begin
            check(g, "bits_before_le_fall", nb, WD);
            if (expq[g].size() == 0) begin
              check(g, "unexpected_word_queue_depth", expq[g].size(), 1);
            end else begin
              p = expq[g].pop_front();
              check(g, "word_l", acc_l & MASK, p.l);
              check(g, "word_r", acc_r & MASK, p.r);
            end
            nlow = 0;
          end
          if (!pe && le[g]) check(g, "le_low_periods", nlow, LL);
          pb = bck[g]; pl = sdo_l[g]; pr = sdo_r[g]; pe = le[g]; pbz = busy[g];
        end
      end
    end
  endgenerate

  // Called at a negedge; returns at a negedge with valid_i still high.
  task automatic send(input int i, input logic [23:0] l, input logic [23:0] r,
                      input bit use_c, input int cl, input int cr);
    int    t;
    pair_t p;
    vld[i] = 1'b1; ls[i] = l; rs[i] = r; t = 0;
    while (!rdy[i] && t < 2000) begin
      @(negedge mck);
      t++;
    end
    if (!rdy[i]) begin
      check(i, "ready_timeout", int'(rdy[i]), 1);
      vld[i] = 1'b0;
      return;
    end
    p.l = use_c ? cl : ref_word(l, lfsr_m[i], wd_of(i), di_of(i));
    p.r = use_c ? cr : ref_word(r, lfsr_m[i], wd_of(i), di_of(i));
    expq[i].push_back(p);
    lfsr_m[i] = lfsr_next(lfsr_m[i]);
    @(posedge mck);
    @(negedge mck);
    check(i, "ready_low_when_full", int'(rdy[i]), 0);
  endtask

  task automatic gap(input int i, input int n);
    vld[i] = 1'b0;
    repeat (n) @(negedge mck);
  endtask

  task automatic init_reset(input int i);
    rst_v[i] = 1'b1; vld[i] = 1'b0; ls[i] = '0; rs[i] = '0;
    repeat (4) @(negedge mck);
    check(i, "reset_ready", int'(rdy[i]), 1);
    check(i, "reset_le", int'(le[i]), 1);
    check(i, "reset_bck", int'(bck[i]), 0);
    check(i, "reset_busy", int'(busy[i]), 0);
    rst_v[i] = 1'b0;
    lfsr_m[i] = 1;
  endtask

  task automatic drain(input int i);
    int t;
    vld[i] = 1'b0; t = 0;
    while ((expq[i].size() != 0 || busy[i]) && t < 20000) begin
      @(negedge mck);
      t++;
    end
    check(i, "drain_queue_depth", expq[i].size(), 0);
  endtask

  task automatic random_run(input int i, input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      send(i, rnd_sample(), rnd_sample(), 1'b0, 0, 0);
      gap(i, $urandom_range(0, max_gap));
    end
  endtask

  task automatic run0();
    int t, seen;
    init_reset(0);
    send(0, 24'h123456, 24'h800000, 1'b1, 'h048D1, 'h20000);
    send(0, 24'h7FFFFF, 24'hFFFFE0, 1'b1, 'h1FFFF, 'h00000);
    send(0, 24'hFFFFDF, 24'h000000, 1'b1, 'h3FFFF, 'h00000);
    gap(0, 200);
    // Backpressure: valid held high across three distinct pairs.
    send(0, 24'h0A0B0C, 24'hF0E0D0, 1'b0, 0, 0);
    send(0, 24'h400000, 24'hC00000, 1'b0, 0, 0);
    send(0, 24'h00FFFF, 24'hFF0001, 1'b0, 0, 0);
    gap(0, 1);
    random_run(0, 15, 120);
    drain(0);
    // Reset in the middle of a word.
    send(0, 24'h555555, 24'hAAAAAA, 1'b0, 0, 0);
    gap(0, 0);
    t = 0;
    while (!busy[0] && t < 500) begin
      @(negedge mck);
      t++;
    end
    check(0, "busy_before_midword_reset", int'(busy[0]), 1);
    repeat (20) @(negedge mck);
    rst_v[0] = 1'b1;
    @(negedge mck);
    check(0, "midreset_le", int'(le[0]), 1);
    check(0, "midreset_sdo_l", int'(sdo_l[0]), 0);
    check(0, "midreset_sdo_r", int'(sdo_r[0]), 0);
    check(0, "midreset_bck", int'(bck[0]), 0);
    check(0, "midreset_ready", int'(rdy[0]), 1);
    check(0, "midreset_busy", int'(busy[0]), 0);
    @(negedge mck);
    rst_v[0] = 1'b0;
    expq[0].delete();
    lfsr_m[0] = 1;
    seen = 0;
    repeat (300) begin
      @(negedge mck);
      if (busy[0] || !le[0]) seen++;
    end
    check(0, "partial_word_discarded", seen, 0);
  endtask

  task automatic run1();
    init_reset(1);
    // Seed 1: d = -31 then d = -30, both round to zero.
    send(1, 24'h000000, 24'h000000, 1'b1, 0, 0);
    send(1, 24'h000000, 24'h000000, 1'b1, 0, 0);
    gap(1, 0);
    random_run(1, 62, 4);
    drain(1);
  endtask

  task automatic run2();
    init_reset(2);
    random_run(2, 25, 3);
    drain(2);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1; vld[i] = 1'b0; ls[i] = '0; rs[i] = '0; lfsr_m[i] = 1;
    end
    fork
      run0();
      run1();
      run2();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
